// File: rtl/r88_pkg.sv
// Rocket88 ALU sequencer shared types.
// State encoding, flag bit positions and the latched command bundle.
package r88_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_EXEC,
    ST_WRITE,
    ST_DONE
  } state_e;

  localparam int FLG_C = 0;
  localparam int FLG_Z = 1;
  localparam int FLG_N = 2;

  typedef struct packed {
    logic [2:0] op;
    logic       inv;
    logic       dec;
    logic       use_carry;
    logic       right_sel;
    logic       wide;
    logic       cmp_only;
  } cmd_ctl_t;

  // Z of a wide result also needs the already-written low byte to be zero.
  function automatic logic [2:0] alu_flags(
    input logic [7:0] res,
    input logic       lo_zero,
    input logic       cout
  );
    logic [2:0] f;
    f        = '0;
    f[FLG_C] = cout;
    f[FLG_Z] = (res == 8'h00) & lo_zero;
    f[FLG_N] = res[7];
    return f;
  endfunction

endpackage

// File: rtl/r88_flag_reg.sv
// Rocket88 {N,Z,C} flag register.
// An ALU update in the same cycle as an external load takes priority.
module r88_flag_reg
  import r88_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       alu_wr,
  input  logic [2:0] alu_flags_i,
  input  logic       ext_wr,
  input  logic [2:0] ext_flags_i,
  output logic [2:0] flags_o
);

  logic [2:0] flags_d;
  logic [2:0] flags_q;

  always_comb begin
    flags_d = flags_q;
    if (alu_wr) begin
      flags_d = alu_flags_i;
    end else if (ext_wr) begin
      flags_d = ext_flags_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign flags_o = flags_q;

endmodule

// File: rtl/r88_alu_seq.sv
// Rocket88 multi-cycle ALU sequencer.
// Runs one pass per byte, chaining carry between the low and high pass.
module r88_alu_seq
  import r88_pkg::*;
#(
  parameter int REG_ADDR_W   = 3,
  parameter int SETUP_CYCLES = 1
) (
  input  logic                  sysClock,
  input  logic                  sysReset,
  input  logic                  cmdValid,
  output logic                  cmdReady,
  input  logic [2:0]            cmdOp,
  input  logic                  cmdInv,
  input  logic                  cmdDec,
  input  logic                  cmdUseCarry,
  input  logic                  cmdRightSel,
  input  logic                  cmdWide,
  input  logic                  cmdCmpOnly,
  input  logic [REG_ADDR_W-1:0] cmdSrcL,
  input  logic [REG_ADDR_W-1:0] cmdSrcR,
  input  logic [REG_ADDR_W-1:0] cmdDst,
  output logic [REG_ADDR_W-1:0] regSelL,
  output logic [REG_ADDR_W-1:0] regSelR,
  output logic [2:0]            aluOp,
  output logic                  invOut,
  output logic                  decMode,
  output logic                  carryInEn,
  output logic                  rightSel,
  output logic                  carryIn,
  input  logic                  aluCarryOut,
  output logic                  aluOutEn,
  input  logic [7:0]            busD,
  output logic                  regWrEn,
  output logic [REG_ADDR_W-1:0] regWrAddr,
  output logic [7:0]            regWrData,
  input  logic                  flagWr,
  input  logic [2:0]            flagIn,
  output logic [2:0]            flags,
  output logic                  busy,
  output logic                  done
);

  localparam logic [1:0] CNT_INIT = 2'(SETUP_CYCLES - 1);

  state_e                state_q, state_d;
  logic [1:0]            cnt_q, cnt_d;
  logic                  pass_q, pass_d;
  cmd_ctl_t              ctl_q, ctl_d;
  logic [REG_ADDR_W-1:0] src_l_q, src_l_d;
  logic [REG_ADDR_W-1:0] src_r_q, src_r_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic [7:0]            byte_q, byte_d;
  logic                  cout_q, cout_d;
  logic                  lo_zero_q, lo_zero_d;

  logic                  accept;
  logic                  final_wr;
  logic [2:0]            upd_flags;

  // Wide ops address a register pair; bit0 selects the byte of the pass.
  function automatic logic [REG_ADDR_W-1:0] pair_addr(
    input logic [REG_ADDR_W-1:0] idx,
    input logic                  wide,
    input logic                  hi
  );
    return wide ? {idx[REG_ADDR_W-1:1], hi} : idx;
  endfunction

  assign accept   = cmdValid & cmdReady;
  assign final_wr = (state_q == ST_WRITE) & (~ctl_q.wide | pass_q);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pass_d    = pass_q;
    ctl_d     = ctl_q;
    src_l_d   = src_l_q;
    src_r_d   = src_r_q;
    dst_d     = dst_q;
    byte_d    = byte_q;
    cout_d    = cout_q;
    lo_zero_d = lo_zero_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (accept) begin
          ctl_d.op        = cmdOp;
          ctl_d.inv       = cmdInv;
          ctl_d.dec       = cmdDec;
          ctl_d.use_carry = cmdUseCarry;
          ctl_d.right_sel = cmdRightSel;
          ctl_d.wide      = cmdWide;
          ctl_d.cmp_only  = cmdCmpOnly;
          src_l_d         = cmdSrcL;
          src_r_d         = cmdSrcR;
          dst_d           = cmdDst;
          pass_d          = 1'b0;
          lo_zero_d       = 1'b1;
          cnt_d           = CNT_INIT;
          state_d         = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (cnt_q == 2'd0) begin
          state_d = ST_EXEC;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      ST_EXEC: begin
        byte_d  = busD;
        cout_d  = aluCarryOut;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        if (ctl_q.wide && !pass_q) begin
          pass_d    = 1'b1;
          lo_zero_d = (byte_q == 8'h00);
          cnt_d     = CNT_INIT;
          state_d   = ST_SETUP;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sysClock) begin
    if (sysReset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pass_q    <= 1'b0;
      ctl_q     <= '0;
      src_l_q   <= '0;
      src_r_q   <= '0;
      dst_q     <= '0;
      byte_q    <= '0;
      cout_q    <= 1'b0;
      lo_zero_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pass_q    <= pass_d;
      ctl_q     <= ctl_d;
      src_l_q   <= src_l_d;
      src_r_q   <= src_r_d;
      dst_q     <= dst_d;
      byte_q    <= byte_d;
      cout_q    <= cout_d;
      lo_zero_q <= lo_zero_d;
    end
  end

  always_comb begin
    cmdReady  = (state_q == ST_IDLE) | (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    done      = (state_q == ST_DONE);
    aluOutEn  = (state_q == ST_EXEC);
    regWrEn   = (state_q == ST_WRITE) & ~ctl_q.cmp_only;
    regSelL   = '0;
    regSelR   = '0;
    regWrAddr = '0;
    regWrData = '0;
    aluOp     = '0;
    invOut    = 1'b0;
    decMode   = 1'b0;
    rightSel  = 1'b0;
    carryInEn = 1'b0;
    carryIn   = 1'b0;
    if ((state_q == ST_SETUP) || (state_q == ST_EXEC)) begin
      regSelL = pair_addr(src_l_q, ctl_q.wide, pass_q);
      regSelR = pair_addr(src_r_q, ctl_q.wide, pass_q);
    end
    if (state_q == ST_WRITE) begin
      regWrAddr = pair_addr(dst_q, ctl_q.wide, pass_q);
      regWrData = byte_q;
    end
    if (busy) begin
      aluOp     = ctl_q.op;
      invOut    = ctl_q.inv;
      decMode   = ctl_q.dec;
      rightSel  = ctl_q.right_sel;
      carryInEn = pass_q ? 1'b1 : ctl_q.use_carry;
      carryIn   = pass_q ? cout_q : flags[FLG_C];
    end
  end

  assign upd_flags = alu_flags(byte_q, ctl_q.wide ? lo_zero_q : 1'b1, cout_q);

  r88_flag_reg u_flags (
    .clk         (sysClock),
    .rst         (sysReset),
    .alu_wr      (final_wr),
    .alu_flags_i (upd_flags),
    .ext_wr      (flagWr),
    .ext_flags_i (flagIn),
    .flags_o     (flags)
  );

endmodule
